// File: rtl/simplebus_req_sequencer.sv
// Command sequencer for the simplebus leader: buffers read/write commands, issues them
// one at a time with an enforced idle gap, returns read data and flags stuck transactions.
module simplebus_req_sequencer #(
  parameter int DEPTH   = 4,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_read,
  input  logic [15:0]              cmd_addr,
  input  logic [7:0]               cmd_wdata,
  output logic                     ld_access,
  output logic                     ld_do_read,
  output logic [15:0]              ld_addr,
  output logic [7:0]               ld_wdata,
  output logic                     ld_wdata_rdy,
  input  logic                     ld_idle,
  input  logic                     ld_rdata_valid,
  input  logic [7:0]               ld_rdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LEAVE,
    S_WAIT_DONE
  } state_t;

  state_t          state;
  logic            mem_read  [DEPTH];
  logic [15:0]     mem_addr  [DEPTH];
  logic [7:0]      mem_wdata [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [3:0]      gap_cnt;
  logic [TW-1:0]   to_cnt;

  logic            push;
  logic            pop;
  logic            head_read;
  logic [15:0]     head_addr;
  logic [7:0]      head_wdata;
  logic            can_issue;

  // Full blocks pushes regardless of a same-cycle pop, so the FIFO never overruns.
  assign cmd_ready  = (fifo_count != CW'(DEPTH));
  assign push       = cmd_valid & cmd_ready;
  assign head_read  = mem_read[rd_ptr];
  assign head_addr  = mem_addr[rd_ptr];
  assign head_wdata = mem_wdata[rd_ptr];

  // A pending response blocks only reads, so read data can never be overwritten.
  assign can_issue = (state == S_IDLE) && (fifo_count != '0) && (gap_cnt == 4'd0) &&
                     ld_idle && (!head_read || !rsp_valid);
  assign pop       = can_issue;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_read[i]  <= 1'b0;
        mem_addr[i]  <= 16'h0000;
        mem_wdata[i] <= 8'h00;
      end
    end else begin
      if (push) begin
        mem_read[wr_ptr]  <= cmd_read;
        mem_addr[wr_ptr]  <= cmd_addr;
        mem_wdata[wr_ptr] <= cmd_wdata;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      ld_access    <= 1'b0;
      ld_do_read   <= 1'b0;
      ld_addr      <= 16'h0000;
      ld_wdata     <= 8'h00;
      ld_wdata_rdy <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= 8'h00;
      err_timeout  <= 1'b0;
      gap_cnt      <= 4'(GAP);
      to_cnt       <= '0;
    end else begin
      ld_access <= 1'b0;
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      // to_cnt holds cycles elapsed since the ISSUE cycle; it saturates at TIMEOUT.
      if (state == S_WAIT_LEAVE || state == S_WAIT_DONE) begin
        if (to_cnt == TW'(TIMEOUT - 1)) begin
          err_timeout <= 1'b1;
        end
        if (to_cnt != TW'(TIMEOUT)) begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
      case (state)
        S_IDLE: begin
          if (ld_idle && gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
          end
          if (can_issue) begin
            state        <= S_ISSUE;
            ld_access    <= 1'b1;
            ld_do_read   <= head_read;
            ld_addr      <= head_addr;
            ld_wdata     <= head_wdata;
            ld_wdata_rdy <= ~head_read;
            to_cnt       <= '0;
          end
        end
        S_ISSUE: begin
          state  <= S_WAIT_LEAVE;
          to_cnt <= TW'(1);
        end
        S_WAIT_LEAVE: begin
          if (!ld_idle) begin
            state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (ld_rdata_valid && ld_do_read) begin
            rsp_data  <= ld_rdata;
            rsp_valid <= 1'b1;
          end
          if (ld_idle) begin
            state        <= S_IDLE;
            gap_cnt      <= 4'(GAP);
            ld_wdata_rdy <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
